// File: rtl/conv_tap_mac.sv
// ============================================================================
//  conv_tap_mac : tap-serial 3x3 convolution MAC with scaled, rectified,
//                 saturated result on a valid/ready output.   Rev 1.0
// ============================================================================
`default_nettype none

module conv_tap_mac #(
   parameter int NTAP  = 9,
   parameter int DW    = 8,
   parameter int WW    = 8,
   parameter int AW    = 20,
   parameter int OW    = 8,
   parameter int SHIFT = 4,
   parameter int RELU  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [3:0]           sel,
   input  logic                 ctl_clear,
   input  logic                 ctl_dump,
   input  logic [NTAP*DW-1:0]   pix_in,
   input  logic [NTAP*WW-1:0]   wgt_in,
   output logic [OW-1:0]        out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 ovf
);

   localparam logic [3:0]           C_NTAP = 4'(NTAP);
   localparam logic signed [AW-1:0] C_OMAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
   localparam logic signed [AW-1:0] C_OMIN = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

   logic [3:0]              sel_prev_q, sel_prev_d;
   logic signed [DW+WW-1:0] prod_q, prod_d;
   logic                    prod_vld_q, prod_vld_d;
   logic signed [AW-1:0]    acc_q, acc_d;
   logic [OW-1:0]           out_data_q, out_data_d;
   logic                    out_valid_q, out_valid_d;
   logic                    ovf_q, ovf_d;

   logic signed [DW-1:0]    pix_sel;
   logic signed [WW-1:0]    wgt_sel;
   logic                    capture;
   logic signed [AW-1:0]    add;
   logic signed [AW-1:0]    pre;
   logic signed [AW-1:0]    shifted;
   logic [OW-1:0]           result;
   logic                    dump;

   always_comb begin
      pix_sel = '0;
      wgt_sel = '0;
      for (int k = 0; k < NTAP; k++) begin
         if (sel == 4'(k)) begin
            pix_sel = pix_in[k*DW +: DW];
            wgt_sel = wgt_in[k*WW +: WW];
         end
      end

      // Dropping en forces sel_prev to the idle code so the next select re-captures
      sel_prev_d = en ? sel : 4'hF;
      capture    = en && (sel < C_NTAP) && (sel != sel_prev_q);
      prod_d     = capture ? pix_sel * wgt_sel : prod_q;
      prod_vld_d = capture;

      add   = prod_vld_q ? {{(AW-DW-WW){prod_q[DW+WW-1]}}, prod_q} : '0;
      pre   = acc_q + add;
      acc_d = (en && ctl_clear) ? add : pre;

      shifted = pre >>> SHIFT;
      if ((RELU != 0) && shifted[AW-1])
         result = '0;
      else if (shifted > C_OMAX)
         result = {1'b0, {(OW-1){1'b1}}};
      else if (shifted < C_OMIN)
         result = {1'b1, {(OW-1){1'b0}}};
      else
         result = shifted[OW-1:0];

      // A dump lands only when the output slot is free or being consumed this cycle
      dump        = en && ctl_dump;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      ovf_d       = ovf_q;
      if (dump) begin
         if (!out_valid_q || out_ready) begin
            out_data_d  = result;
            out_valid_d = 1'b1;
         end else begin
            ovf_d = 1'b1;
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_prev_q  <= 4'hF;
         prod_q      <= '0;
         prod_vld_q  <= 1'b0;
         acc_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         sel_prev_q  <= sel_prev_d;
         prod_q      <= prod_d;
         prod_vld_q  <= prod_vld_d;
         acc_q       <= acc_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         ovf_q       <= ovf_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign ovf       = ovf_q;

endmodule

`default_nettype wire
